// File: rtl/trace_retire_buffer_if.sv
// trace_retire_buffer_if: record-in / record-out bundle for trace_retire_buffer.
//   in_*      retired-instruction record from writeback (in_valid strobe)
//   flush     synchronous clear of buffer, drop counter and sticky flag
//   out_*     head record, valid/ready handshake towards the logger
//   level/full/overflow/drop_count  occupancy and loss status
// Optional macro TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN adds out_cycle.
// Modports: slave = buffer side, master = producer/consumer side.
interface trace_retire_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [31:0]       in_instruction;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic [31:0]       in_rd_value;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instruction;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [31:0]       out_imm;
  logic [31:0]       out_rd_value;
  logic [LW-1:0]     level;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
  logic [31:0]       out_cycle;
`endif

  modport slave (
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
    output out_cycle,
`endif
    input  in_valid, in_instruction, in_rd, in_rs1, in_rs2, in_imm, in_rd_value,
    input  flush, out_ready,
    output out_valid, out_instruction, out_rd, out_rs1, out_rs2, out_imm,
    output out_rd_value, level, full, overflow, drop_count
  );

  modport master (
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
    input  out_cycle,
`endif
    output in_valid, in_instruction, in_rd, in_rs1, in_rs2, in_imm, in_rd_value,
    output flush, out_ready,
    input  out_valid, out_instruction, out_rd, out_rs1, out_rs2, out_imm,
    input  out_rd_value, level, full, overflow, drop_count
  );
endinterface

// File: rtl/trace_retire_buffer.sv
// trace_retire_buffer: FWFT capture FIFO between CPU writeback and the trace
// logger. Never back-pressures the pipeline; records that find no slot are
// dropped and counted (saturating drop_count, sticky overflow).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    trace_retire_buffer_if.slave (record in, record out, status)
// Optional macro TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN: stamps each accepted
// record with a free-running 32-bit cycle count, presented on bus.out_cycle.
module trace_retire_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  trace_retire_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [31:0] instruction;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] rd_value;
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
    logic [31:0] cycle;
`endif
  } rec_t;

  rec_t              mem [DEPTH];
  rec_t              wr_rec;
  rec_t              head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q;
  logic [DROP_W-1:0] drop_q;
  logic              ovf_q;
  logic              cand, pop, accept, drop;
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
  logic [31:0]       cyc_q;
`endif

  // Zero instruction words are pipeline bubbles, not records.
  assign cand   = bus.in_valid && (bus.in_instruction != 32'h0);
  assign pop    = (level_q != '0) && bus.out_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign accept = cand && ((level_q < LW'(DEPTH)) || pop);
  assign drop   = cand && !accept;

  always_comb begin
    wr_rec             = '0;
    wr_rec.instruction = bus.in_instruction;
    wr_rec.rd          = bus.in_rd;
    wr_rec.rs1         = bus.in_rs1;
    wr_rec.rs2         = bus.in_rs2;
    wr_rec.imm         = bus.in_imm;
    wr_rec.rd_value    = bus.in_rd_value;
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
    wr_rec.cycle       = cyc_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !accept) level_q <= level_q - 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; contents are only observed under out_valid.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && accept) mem[wr_ptr] <= wr_rec;
  end

`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) cyc_q <= '0;
    else                     cyc_q <= cyc_q + 1'b1;
  end
  assign bus.out_cycle = head.cycle;
`endif

  // Registered storage read: no combinational in_* -> out_* path.
  assign head                = mem[rd_ptr];
  assign bus.out_valid       = (level_q != '0);
  assign bus.out_instruction = head.instruction;
  assign bus.out_rd          = head.rd;
  assign bus.out_rs1         = head.rs1;
  assign bus.out_rs2         = head.rs2;
  assign bus.out_imm         = head.imm;
  assign bus.out_rd_value    = head.rd_value;
  assign bus.level           = level_q;
  assign bus.full            = (level_q == LW'(DEPTH));
  assign bus.overflow        = ovf_q;
  assign bus.drop_count      = drop_q;
endmodule

// File: tb/tb_trace_retire_buffer.sv
// Bench for trace_retire_buffer: directed steps followed by a random phase,
// all checked every cycle against a queue-based reference model.
module tb_trace_retire_buffer;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int MAXD   = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trace_retire_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();
  trace_retire_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, val, cyc;
  } mrec_t;

  mrec_t       q[$];
  int          m_drop;
  bit          m_ovf;
  logic [31:0] m_cyc;
  int          n_asrt = 0;
  int          n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [31:0] ins);
    bus.in_valid       = v;
    bus.in_instruction = ins;
    bus.in_rd          = 5'($urandom);
    bus.in_rs1         = 5'($urandom);
    bus.in_rs2         = 5'($urandom);
    bus.in_imm         = $urandom;
    bus.in_rd_value    = $urandom;
  endtask

  task automatic check_all();
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
    if (q.size() > 0) begin
      chk("head_ins", bus.out_instruction, q[0].ins);
      chk("head_rd", 32'(bus.out_rd), 32'(q[0].rd));
      chk("head_rs1", 32'(bus.out_rs1), 32'(q[0].rs1));
      chk("head_rs2", 32'(bus.out_rs2), 32'(q[0].rs2));
      chk("head_imm", bus.out_imm, q[0].imm);
      chk("head_val", bus.out_rd_value, q[0].val);
`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
      chk("head_cyc", bus.out_cycle, q[0].cyc);
`endif
    end
  endtask

  // Apply the model's rule for one cycle using the currently driven inputs,
  // then clock the DUT and compare.
  task automatic tick();
    mrec_t r;
    bit pop, cand, acc;
    pop  = (q.size() > 0) && bus.out_ready;
    cand = bus.in_valid && (bus.in_instruction != 0);
    if (!rst_n || bus.flush) begin
      q.delete(); m_drop = 0; m_ovf = 0; m_cyc = 0;
    end else begin
      acc   = cand && ((q.size() < DEPTH) || pop);
      r.ins = bus.in_instruction; r.rd = bus.in_rd; r.rs1 = bus.in_rs1;
      r.rs2 = bus.in_rs2; r.imm = bus.in_imm; r.val = bus.in_rd_value;
      r.cyc = m_cyc;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(r);
      if (cand && !acc) begin
        m_ovf = 1;
        if (m_drop < MAXD) m_drop++;
      end
      m_cyc = m_cyc + 1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  logic [31:0] saved [DEPTH];
  logic [31:0] tp_ins [3];

  initial begin
    tp_ins[0] = 32'h00500093; tp_ins[1] = 32'h00A00113; tp_ins[2] = 32'h002081B3;
    m_cyc = 0; m_drop = 0; m_ovf = 0;
    rst_n = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678);
    #1;
    tick(); tick();
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_drop", 32'(bus.drop_count), 0);
    rst_n = 1'b1;

    // Three records held, then drained in order.
    for (int i = 0; i < 3; i++) begin drive(1'b1, tp_ins[i]); tick(); end
    drive(1'b0, 32'h0); tick();
    chk("tp1_level", 32'(bus.level), 3);
    chk("tp1_valid", 32'(bus.out_valid), 1);
    chk("tp1_head", bus.out_instruction, 32'h00500093);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("tp1_order", bus.out_instruction, tp_ins[i]);
      tick();
    end
    chk("tp1_empty_level", 32'(bus.level), 0);
    chk("tp1_empty_valid", 32'(bus.out_valid), 0);

    // Bubbles are ignored and never counted.
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h0); tick(); end
    chk("tp2_level", 32'(bus.level), 0);
    chk("tp2_drop", 32'(bus.drop_count), 0);
    chk("tp2_ovf", 32'(bus.overflow), 0);

    // Overfill with consumer stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom | 32'h1);
      if (i < DEPTH) saved[i] = bus.in_instruction;
      tick();
    end
    drive(1'b0, 32'h0);
    chk("tp3_full", 32'(bus.full), 1);
    chk("tp3_level", 32'(bus.level), 16);
    chk("tp3_drop", 32'(bus.drop_count), 4);
    chk("tp3_ovf", 32'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("tp3_order", bus.out_instruction, saved[i]);
      tick();
    end
    chk("tp3_drained", 32'(bus.level), 0);
    chk("tp3_ovf_sticky", 32'(bus.overflow), 1);

    // Full with simultaneous push and pop, then saturate the drop counter.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin drive(1'b1, $urandom | 32'h1); tick(); end
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_0001); tick();
    chk("tp4_level", 32'(bus.level), 16);
    chk("tp4_drop", 32'(bus.drop_count), 4);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin drive(1'b1, $urandom | 32'h1); tick(); end
    chk("tp4_sat", 32'(bus.drop_count), 15);
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("tp4_last", bus.out_instruction, 32'hDEAD_0001);
    tick();

    // Flush with a concurrent push clears everything, counter included.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1'b1, $urandom | 32'h1); tick(); end
    bus.flush = 1'b1;
    drive(1'b1, 32'hF00D_0001); tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("tp5_level", 32'(bus.level), 0);
    chk("tp5_valid", 32'(bus.out_valid), 0);
    chk("tp5_drop", 32'(bus.drop_count), 0);
    chk("tp5_ovf", 32'(bus.overflow), 0);
    tick();
    chk("tp5_absent", 32'(bus.level), 0);

`ifdef TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    while (m_cyc != 10) tick();
    drive(1'b1, 32'hC0DE_000A); tick();
    drive(1'b0, 32'h0);
    while (m_cyc != 13) tick();
    drive(1'b1, 32'hC0DE_000D); tick();
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b1;
    chk("stamp_first", bus.out_cycle, 10);
    tick();
    chk("stamp_second", bus.out_cycle, 13);
    tick();
`endif

    // Random traffic, with occasional flush and mid-stream reset.
    for (int i = 0; i < 800; i++) begin
      rst_n         = ($urandom_range(0, 249) != 0);
      bus.flush     = ($urandom_range(0, 79) == 0);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_retire_buffer.md
Name: trace_retire_buffer

Overview:
- Capture stage directly upstream of the trace logger.
- Accepts one retired-instruction record per cycle from the CPU writeback stage: instruction, rd, rs1, rs2, imm, rd value.
- Buffers records in a first-word-fall-through FIFO and presents them to the logger or serializer over a valid/ready handshake.
- Counts records lost to overflow, so a stalled consumer never stalls the pipeline.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  retire strobe from writeback.
- in_instruction  in  32  retired instruction word.
- in_rd  in  5  destination register index.
- in_rs1  in  5  source register 1 index.
- in_rs2  in  5  source register 2 index.
- in_imm  in  32  signed decoded immediate.
- in_rd_value  in  32  signed value written to rd.
- flush  in  1  synchronous clear of FIFO, counter and sticky flag.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_instruction  out  32  head record field.
- out_rd  out  5  head record field.
- out_rs1  out  5  head record field.
- out_rs2  out  5  head record field.
- out_imm  out  32  head record field.
- out_rd_value  out  32  head record field.
- level  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; set on the first dropped record.
- drop_count  out  DROP_W  dropped-record count; saturates at all ones.

Behaviour:
- Reset (rst_n low at a clock edge): level=0, out_valid=0, full=0, overflow=0, drop_count=0, read/write pointers=0. out_* data fields are don't-care while out_valid=0.
- Reset mid-operation: in-flight records are discarded; no partial pop.
- Record qualification: push candidate when in_valid=1 and in_instruction != 32'h0.
  - Zero-instruction bubbles are silently ignored.
  - Bubbles are never counted as drops.
- pop = out_valid & out_ready.
- Push acceptance: accepted when level < DEPTH, or when full and pop occurs in the same cycle (slot freed and refilled).
- Drop rule: a push candidate that is not accepted is a drop.
  - drop_count increments by 1, holding at 2^DROP_W-1.
  - overflow is set and stays set until flush or reset.
- level update per cycle:
  - +1 on accepted push without pop.
  - -1 on pop without accepted push.
  - Unchanged when both occur, or neither.
- Latency: a record accepted at edge N is visible on out_* with out_valid=1 after edge N (one cycle).
  - No combinational path from in_* to out_*.
- Head hold: out_* fields stay stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0; out_ready is ignored.
- Pointers wrap modulo DEPTH. Ordering is strict FIFO.
- flush: same effect as reset on the next edge. A push candidate in the flush cycle is discarded and not counted.
- Priority: rst_n > flush > normal operation.
- Field widths are passed through unchanged; signedness of imm and rd_value is preserved bit-for-bit.

Optional Feature:
- Macro: TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter runs; reset to 0 by rst_n and flush, wrapping at 2^32.
  - Each accepted record stores the counter value from its push cycle.
  - Extra output port out_cycle [31:0] presents the head record's stamp.
  - FIFO entry width grows by 32 bits.
- When undefined: no counter and no out_cycle port. Behaviour is otherwise identical.

Test Plan:
- Reset, then push 3 records (instr 32'h00500093, 32'h00A00113, 32'h002081B3) with out_ready=0 -> level=3, out_valid=1, head=32'h00500093; then out_ready=1 for 3 cycles -> records pop in order, level=0, out_valid=0.
- in_valid=1 with in_instruction=0 for 5 cycles -> level stays 0, drop_count=0, overflow=0.
- DEPTH=16, out_ready=0, 20 valid pushes -> full=1, level=16, drop_count=4, overflow=1; then drain all -> the first 16 records emerge in order; overflow remains 1.
- Full FIFO, simultaneous push and pop -> push accepted, level stays 16, drop_count unchanged, new record emerges last.
- Four records queued, assert flush for one cycle while also pushing -> next cycle level=0, out_valid=0, drop_count=0, overflow=0; pushed record absent.
- With TRACE_RETIRE_BUFFER_CYCLE_STAMP_EN: push at cycles 10 and 13 after reset -> out_cycle reads 10 then 13 as records pop.
